// File: rtl/wb_timer_slave.sv
// wb_timer_slave
//   Wishbone B4 classic slave that bridges the data bus onto the timer's
//   simple register port. It decodes a 16-byte, 4-word window at BASE_ADDR.
//   Each access takes three cycles: latch, access, respond.
//   Partial writes are merged against the timer's current register value.
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   wb_cyc_i/stb_i/we_i   Wishbone cycle, strobe, write enable
//   wb_adr_i/dat_i/sel_i  byte address, write data, byte selects
//   wb_dat_o              read data, valid with wb_ack_o and held until the next read
//   wb_ack_o/err_o        one-cycle normal/error termination
//   reg_we_o/addr_o       timer write strobe and word index (0 ctrl, 1 period, 2 value)
//   reg_din_o             byte-merged timer write data
//   reg_dout_i            timer read data, combinational from reg_addr_o
module wb_timer_slave #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 'h4000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              reg_we_o,
  output logic [1:0]        reg_addr_o,
  output logic [31:0]       reg_din_o,
  input  logic [31:0]       reg_dout_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic                we_q, we_d;
  logic [31:0]         dat_q, dat_d;
  logic [3:0]          sel_q, sel_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [31:0]         rdat_q, rdat_d;

  logic [1:0]          idx;
  logic                legal;
  logic [31:0]         merged;

  assign idx   = adr_q[3:2];
  // ctrl and period are writable, value is read-only, and idx 3 is unmapped.
  assign legal = (adr_q[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]) &&
                 (adr_q[1:0] == 2'b00) &&
                 (we_q ? (idx <= 2'd1) : (idx <= 2'd2));

  // Unselected bytes keep the timer's current contents, so sel = 0 rewrites
  // the register with its own value.
  always_comb begin
    merged = reg_dout_i;
    for (int n = 0; n < 4; n++)
      if (sel_q[n]) merged[8*n +: 8] = dat_q[8*n +: 8];
  end

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    we_d      = we_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdat_d    = rdat_q;
    reg_we_o  = 1'b0;
    reg_din_o = '0;
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          adr_d   = wb_adr_i;
          we_d    = wb_we_i;
          dat_d   = wb_dat_i;
          sel_d   = wb_sel_i;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!wb_cyc_i) begin
          // The master abandoned the cycle, so the timer is not touched and no termination is sent.
          state_d = IDLE;
        end else begin
          state_d = RESP;
          ack_d   = legal;
          err_d   = !legal;
          if (we_q) reg_din_o = merged;
          if (legal && we_q) reg_we_o = 1'b1;
          if (legal && !we_q) rdat_d = reg_dout_i;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_dat_o   = rdat_q;
  assign reg_addr_o = idx;

endmodule

// File: tb/tb_wb_timer_slave.sv
// Testbench for wb_timer_slave. It contains a small timer stub that models
// ctrl, period and value. A register-level reference model predicts every
// bus response and every timer write.
module tb_wb_timer_slave;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic        reg_we_o;
  logic [1:0]  reg_addr_o;
  logic [31:0] reg_din_o, reg_dout_i;

  always #5 clk = ~clk;

  wb_timer_slave #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o),
    .reg_din_o(reg_din_o), .reg_dout_i(reg_dout_i)
  );

  // Timer stub: ctrl[0] enables counting, and value wraps after reaching period.
  logic [31:0] t_ctrl, t_period, t_value;
  always_comb begin
    case (reg_addr_o)
      2'd0:    reg_dout_i = t_ctrl;
      2'd1:    reg_dout_i = t_period;
      2'd2:    reg_dout_i = t_value;
      default: reg_dout_i = 32'h0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_ctrl   <= 32'h0;
      t_period <= 32'hFFFF_FFFF;
      t_value  <= 32'h0;
    end else begin
      if (reg_we_o && reg_addr_o == 2'd0) t_ctrl   <= reg_din_o;
      if (reg_we_o && reg_addr_o == 2'd1) t_period <= reg_din_o;
      if (t_ctrl[0]) t_value <= (t_value >= t_period) ? 32'h0 : t_value + 32'd1;
    end
  end

  // Reference model state
  logic [31:0] m_ctrl, m_period, m_rdat;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 32'h0; m_period = 32'hFFFF_FFFF; m_rdat = 32'h0;
  endtask

  function automatic bit is_legal(input bit we, input logic [31:0] adr);
    int idx;
    idx = int'(adr[3:2]);
    return (adr[31:4] == BASE[31:4]) && (adr[1:0] == 2'b00) &&
           (we ? (idx <= 1) : (idx <= 2));
  endfunction

  // One complete transaction. It checks the timer port during the access
  // cycle, the latency and kind of termination, the read data, and the
  // single-cycle pulse.
  task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input bit scramble);
    bit          legal, got;
    int          lat, idx;
    logic [31:0] old, exp_din, acc_val;
    legal = is_legal(we, adr);
    idx   = int'(adr[3:2]);
    old   = (idx == 0) ? m_ctrl : m_period;
    exp_din = old;
    for (int n = 0; n < 4; n++) if (sel[n]) exp_din[8*n +: 8] = dat[8*n +: 8];
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    @(negedge clk);                                   // access cycle
    chk("reg_we_access", 32'(reg_we_o), 32'(legal && we));
    chk("reg_addr", 32'(reg_addr_o), 32'(idx));
    if (legal && we) chk("reg_din", reg_din_o, exp_din);
    chk("early_term", 32'({wb_ack_o, wb_err_o}), 32'h0);
    acc_val = t_value;
    if (scramble) begin
      wb_adr_i = $urandom; wb_dat_i = $urandom; wb_sel_i = 4'($urandom);
      wb_we_i = ~we;
    end
    got = 1'b0; lat = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (wb_ack_o || wb_err_o) begin got = 1'b1; lat = i; end
      else chk("reg_we_wait", 32'(reg_we_o), 32'h0);
    end
    if (!got) chk("timeout", 32'h0, 32'h1);
    else begin
      chk("latency", 32'(lat), 32'h0);
      chk("ack", 32'(wb_ack_o), 32'(legal));
      chk("err", 32'(wb_err_o), 32'(!legal));
    end
    if (legal && we) begin
      if (idx == 0) m_ctrl = exp_din; else m_period = exp_din;
    end
    if (legal && !we)
      m_rdat = (idx == 0) ? m_ctrl : (idx == 1) ? m_period : acc_val;
    chk("rdata", wb_dat_o, m_rdat);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    chk("pulse", 32'({wb_ack_o, wb_err_o}), 32'h0);
    chk("ctrl", t_ctrl, m_ctrl);
    chk("period", t_period, m_period);
  endtask

  logic [31:0] v1, v2;
  logic [31:0] addrs [8];

  initial begin
    rst_n = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'({wb_ack_o, wb_err_o, reg_we_o}), 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_addr", 32'(reg_addr_o), 32'h0);
    chk("rst_din", reg_din_o, 32'h0);
    rst_n = 1'b1;

    // Read period, then a partial write and readback
    xfer(1'b0, BASE + 4, 32'h0, 4'hF, 1'b0);
    chk("t1_period", wb_dat_o, 32'hFFFF_FFFF);
    xfer(1'b1, BASE + 4, 32'h0000_00AA, 4'b0001, 1'b0);
    xfer(1'b0, BASE + 4, 32'h0, 4'hF, 1'b0);
    chk("t2_period", wb_dat_o, 32'hFFFF_FFAA);

    // Enable the counter and check that value advances
    xfer(1'b1, BASE + 0, 32'h1, 4'hF, 1'b0);
    repeat (10) @(negedge clk);
    xfer(1'b0, BASE + 8, 32'h0, 4'hF, 1'b0);
    v1 = wb_dat_o;
    chk("t3_range", 32'(v1 >= 32'd8 && v1 <= 32'd14), 32'h1);
    xfer(1'b0, BASE + 8, 32'h0, 4'hF, 1'b0);
    v2 = wb_dat_o;
    chk("t3_incr", 32'(v2 > v1), 32'h1);

    // Illegal accesses
    xfer(1'b1, BASE + 8,    32'h1234_5678, 4'hF, 1'b0);
    xfer(1'b1, BASE + 12,   32'h1234_5678, 4'hF, 1'b0);
    xfer(1'b0, BASE + 12,   32'h0, 4'hF, 1'b0);
    xfer(1'b0, BASE + 2,    32'h0, 4'hF, 1'b0);
    xfer(1'b0, BASE + 16,   32'h0, 4'hF, 1'b0);
    xfer(1'b1, BASE + 1,    32'hDEAD_BEEF, 4'hF, 1'b0);

    // Abort: cyc drops during the access cycle
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = BASE; wb_dat_i = 32'h2; wb_sel_i = 4'hF;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    chk("abort_we", 32'(reg_we_o), 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_term", 32'({wb_ack_o, wb_err_o}), 32'h0);
    end
    chk("abort_ctrl", t_ctrl, m_ctrl);
    xfer(1'b0, BASE + 0, 32'h0, 4'hF, 1'b0);

    // Reset asserted while the response is being returned
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = BASE + 4; wb_sel_i = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("t6_ack", 32'(wb_ack_o), 32'h1);
    rst_n = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    chk("t6_term", 32'({wb_ack_o, wb_err_o, reg_we_o}), 32'h0);
    chk("t6_dat", wb_dat_o, 32'h0);
    chk("t6_addr", 32'(reg_addr_o), 32'h0);
    chk("t6_din", reg_din_o, 32'h0);
    rst_n = 1'b1;
    model_reset();
    xfer(1'b0, BASE + 4, 32'h0, 4'hF, 1'b0);

    // Random traffic, including mid-transaction input changes
    addrs[0] = BASE;      addrs[1] = BASE + 4;  addrs[2] = BASE + 8;
    addrs[3] = BASE + 12; addrs[4] = BASE + 2;  addrs[5] = BASE + 16;
    addrs[6] = 32'h1234_5670; addrs[7] = BASE + 5;
    for (int k = 0; k < 150; k++)
      xfer(1'($urandom), addrs[$urandom_range(0, 7)], $urandom,
           4'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
